// File: rtl/add_jump_sequencer.sv
// add_jump_sequencer
//
// Purpose: sequences a small add/jump processor.  It has two jobs:
//   * Program load.  Words from the host are accepted one at a time and
//     presented to the processor with prog=1, each with a one-cycle advance
//     pulse.  An early ld_last fills the rest of the 16-word store with
//     "add 0" filler words.  The cycle after the final pulse, pc must have
//     wrapped back to 0; otherwise err is raised and stays set until the
//     next start.
//   * Run.  With prog=0 it issues advance pulses, either free-running or one
//     per step_req.  It stops on halt_req, on the cycle budget, or (optional)
//     when a pulse leaves pc unchanged.
//
// Optional feature: define SEQ_SELF_LOOP_DETECT_EN to halt a run with
// cause 3 when pc after a pulse equals pc sampled before it.
//
// Handshake: a load word transfers on a rising clk edge where ld_valid and
// ld_ready are both high.  ld_ready is high only in LOAD.  ld_valid at any
// other time is ignored, and the ld_* fields are sampled only on that edge.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ld_valid/ld_ready    host load handshake; ld_last marks the final word
//   ld_value/dest/src/add/jump   word fields, registered on handshake
//   start, run           begin a load / a run (start wins if both are high)
//   step_mode, step_req  single-step control while running
//   halt_req             stop a run (a pulse in flight completes first)
//   max_cycles           run budget in pulses, 0 = unlimited
//   prog, value, dest, src, add, jump, advance   to the processor
//   pc                   processor program counter
//   busy, done, err      status flags
//   halt_cause           0 none, 1 budget, 2 halt_req, 3 self-loop
//   state                FSM state encoding
//   cycle_count          run pulses since run start (saturates at 255)
//   load_count           words presented in the current load (0..16)
module add_jump_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_last,
    input  logic [15:0] ld_value,
    input  logic [1:0]  ld_dest,
    input  logic [1:0]  ld_src,
    input  logic        ld_add,
    input  logic        ld_jump,
    input  logic        start,
    input  logic        run,
    input  logic        step_mode,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic [7:0]  max_cycles,
    output logic        prog,
    output logic [15:0] value,
    output logic [1:0]  dest,
    output logic [1:0]  src,
    output logic        add,
    output logic        jump,
    output logic        advance,
    input  logic [3:0]  pc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  halt_cause,
    output logic [2:0]  state,
    output logic [7:0]  cycle_count,
    output logic [4:0]  load_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LSTRB  = 3'd2,
        S_PAD    = 3'd3,
        S_RUN    = 3'd4,
        S_RSTRB  = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t st;
    logic   last_q;       // ld_last captured with the current word
    logic   chk_pending;  // compare pc with 0 on the next cycle
    logic   halt_pend;    // halt_req seen during a pulse, honoured in RUN
    logic   self_loop;

`ifdef SEQ_SELF_LOOP_DETECT_EN
    logic [3:0] pc_before;
    logic       loop_chk;  // a pulse has completed since RUN entry
    assign self_loop = loop_chk && (pc == pc_before);
`else
    assign self_loop = 1'b0;
`endif

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            ld_ready    <= 1'b0;
            prog        <= 1'b0;
            value       <= '0;
            dest        <= '0;
            src         <= '0;
            add         <= 1'b0;
            jump        <= 1'b0;
            advance     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            halt_cause  <= '0;
            cycle_count <= '0;
            load_count  <= '0;
            last_q      <= 1'b0;
            chk_pending <= 1'b0;
            halt_pend   <= 1'b0;
`ifdef SEQ_SELF_LOOP_DETECT_EN
            pc_before   <= '0;
            loop_chk    <= 1'b0;
`endif
        end else begin
            // pc has already moved on from the final load pulse here.  A
            // start in this same cycle clears err again below.
            if (chk_pending) begin
                chk_pending <= 1'b0;
                if (pc != 4'd0) err <= 1'b1;
            end

            case (st)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        st         <= S_LOAD;
                        ld_ready   <= 1'b1;
                        prog       <= 1'b1;
                        busy       <= 1'b1;
                        load_count <= '0;
                        err        <= 1'b0;
                        done       <= 1'b0;
                        halt_cause <= '0;
                    end else if (run) begin
                        st          <= S_RUN;
                        prog        <= 1'b0;
                        value       <= '0;
                        dest        <= '0;
                        src         <= '0;
                        add         <= 1'b0;
                        jump        <= 1'b0;
                        busy        <= 1'b1;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        halt_cause  <= '0;
                        halt_pend   <= 1'b0;
`ifdef SEQ_SELF_LOOP_DETECT_EN
                        loop_chk    <= 1'b0;
`endif
                    end
                end

                S_LOAD: begin
                    if (ld_valid && ld_ready) begin
                        value      <= ld_value;
                        dest       <= ld_dest;
                        src        <= ld_src;
                        add        <= ld_add;
                        jump       <= ld_jump;
                        last_q     <= ld_last;
                        load_count <= load_count + 5'd1;
                        ld_ready   <= 1'b0;
                        advance    <= 1'b1;
                        st         <= S_LSTRB;
                    end
                end

                S_LSTRB: begin
                    advance <= 1'b0;
                    if (load_count == 5'd16) begin
                        st          <= S_IDLE;
                        prog        <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        chk_pending <= 1'b1;
                    end else if (last_q) begin
                        // Filler word: add 0, no jump.
                        st    <= S_PAD;
                        value <= '0;
                        dest  <= '0;
                        src   <= '0;
                        add   <= 1'b1;
                        jump  <= 1'b0;
                    end else begin
                        st       <= S_LOAD;
                        ld_ready <= 1'b1;
                    end
                end

                S_PAD: begin
                    // Alternate low/high so every filler pulse is one cycle
                    // wide with a one-cycle gap.
                    if (advance) begin
                        advance <= 1'b0;
                        if (load_count == 5'd16) begin
                            st          <= S_IDLE;
                            prog        <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            chk_pending <= 1'b1;
                        end
                    end else begin
                        advance    <= 1'b1;
                        load_count <= load_count + 5'd1;
                    end
                end

                S_RUN: begin
                    if (halt_req || halt_pend) begin
                        st         <= S_HALTED;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        halt_cause <= 2'd2;
                    end else if (max_cycles != 8'd0 && cycle_count == max_cycles) begin
                        st         <= S_HALTED;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        halt_cause <= 2'd1;
                    end else if (self_loop) begin
                        st         <= S_HALTED;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        halt_cause <= 2'd3;
                    end else if (!step_mode || step_req) begin
                        st      <= S_RSTRB;
                        advance <= 1'b1;
                        if (cycle_count != 8'hff) cycle_count <= cycle_count + 8'd1;
`ifdef SEQ_SELF_LOOP_DETECT_EN
                        pc_before <= pc;
`endif
                    end
                end

                S_RSTRB: begin
                    advance <= 1'b0;
                    st      <= S_RUN;
                    if (halt_req) halt_pend <= 1'b1;
`ifdef SEQ_SELF_LOOP_DETECT_EN
                    loop_chk <= 1'b1;
`endif
                end

                default: begin
                    st       <= S_IDLE;
                    advance  <= 1'b0;
                    ld_ready <= 1'b0;
                    prog     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/add_jump_sequencer.md
ADD_JUMP_SEQUENCER -- requirements
Module: add_jump_sequencer

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge system clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: ld_valid in 1, ld_ready out 1, ld_last in 1, ld_value in 16, ld_dest in 2, ld_src in 2, ld_add in 1, ld_jump in 1; host program-load channel.
REQ-003 SHALL have ports: start in 1, load request; run in 1, run request; step_mode in 1; step_req in 1; halt_req in 1; max_cycles in 8, run budget where 0 means unlimited.
REQ-004 SHALL have ports: prog out 1, value out 16, dest out 2, src out 2, add out 1, jump out 1, advance out 1; these drive the processor's like-named inputs.
REQ-005 SHALL have ports: pc in 4, processor program counter; busy out 1; done out 1; err out 1; halt_cause out 2 (0 none, 1 budget, 2 halt_req, 3 self-loop); state out 3; cycle_count out 8; load_count out 5.

Function
REQ-006 SHALL implement states IDLE=0, LOAD=1, LSTRB=2, PAD=3, RUN=4, RSTRB=5, HALTED=6.
REQ-007 IDLE: start -> LOAD; clear load_count, err, done, halt_cause. run (start low) -> RUN; clear cycle_count, done, halt_cause. start and run both high -> start wins.
REQ-008 LOAD: ld_ready=1, prog=1; on ld_valid&&ld_ready, register ld_* onto value/dest/src/add/jump, increment load_count, go LSTRB.
REQ-009 LSTRB: ld_ready=0, advance=1 for exactly one cycle, fields held stable. Next: load_count==16 -> IDLE with done=1; ld_last captured -> PAD; else LOAD.
REQ-010 PAD: drive filler word add=1, jump=0, value=0, dest=0, src=0 with one-cycle advance pulse every second cycle until load_count==16, then IDLE with done=1.
REQ-011 Load completion SHALL check pc==0 one cycle after the final pulse; mismatch sets err=1 (sticky until next start).
REQ-012 ld_valid while ld_ready=0 SHALL be ignored; ld_* fields SHALL be sampled only on handshake.
REQ-013 RUN: prog=0; value/dest/src/add/jump=0. step_mode=0 -> go RSTRB next cycle. step_mode=1 -> wait for step_req, then RSTRB.
REQ-014 RSTRB: advance=1 for one cycle, sample pc before pulse, cycle_count increments (saturates at 255), return to RUN.
REQ-015 advance SHALL never be high on two consecutive cycles; minimum low gap is one cycle.
REQ-016 Exit RUN to HALTED, checked on RUN entry, in priority order: halt_req (cause 2), max_cycles!=0 and cycle_count==max_cycles (cause 1), self-loop (cause 3, REQ-024).
REQ-017 halt_req in RSTRB SHALL let the pulse complete, then halt.
REQ-018 HALTED: done=1, busy=0; start or run restarts per REQ-007; outputs otherwise held.
REQ-019 busy=1 in every state except IDLE and HALTED; state output equals state encoding.
REQ-020 halt_req, step_req outside RUN/IDLE-run paths SHALL be ignored; step_req held high produces one pulse per RUN visit.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE and set all outputs to 0, including advance, prog, ld_ready, counters, err, halt_cause.
REQ-022 Reset mid-load or mid-pulse SHALL drop advance in the same cycle; no partial pulse extends past reset assertion.
REQ-023 Release of rst_n SHALL take effect on the next rising clk edge; first transition needs start or run.

Configuration
REQ-024 With SEQ_SELF_LOOP_DETECT_EN defined, RUN SHALL halt with cause 3 when pc after a pulse equals pc sampled before it. Without it, pc is used only in REQ-011, and halting occurs only via halt_req or budget.

Verification
REQ-025 Load 16 words, no gaps: ld_valid held high -> 16 advance pulses, prog=1 throughout, done=1, load_count=16, err=0 with pc wrapped to 0.
REQ-026 Load 3 words with ld_last on word 3 -> 13 filler pulses (add=1, value=0), load_count=16, done=1.
REQ-027 run, step_mode=0, max_cycles=5 -> exactly 5 advance pulses, each one cycle wide with low gaps, HALTED, halt_cause=1, cycle_count=5.
REQ-028 step_mode=1, three step_req pulses, then halt_req -> 3 advance pulses, halt_cause=2.
REQ-029 With SEQ_SELF_LOOP_DETECT_EN, program jump-to-self at address 2, max_cycles=0 -> halts after the pulse leaving pc=2 unchanged, halt_cause=3. Without the macro: runs to halt_req.
REQ-030 rst_n asserted during LSTRB -> advance=0, prog=0, state=0 immediately, without waiting for clk.
